// File: rtl/clk_ratio_detector.sv
// clk_ratio_detector
//   Measures the interval between toggles of an asynchronous divided clock
//   (clk_in) in units of the system clock, and reports lock once the
//   interval has been stable for LOCK_COUNT consecutive measurements.
//
//   Parameters:
//     CNT_W       width of the interval counter and half_period
//     LOCK_COUNT  consecutive matching intervals needed for lock (1..15)
//
//   Ports:
//     clk           system clock (rising edge)
//     rst           synchronous active-high reset
//     clk_in        divided clock under measurement (async to clk)
//     clr           synchronous restart of measurement, clears overflow
//     clk_in_sync   clk_in after the 2-flop synchronizer
//     edge_det      one-cycle pulse per detected clk_in toggle
//     half_period   last measured interval between toggles, in clk cycles
//     period_valid  one-cycle pulse when half_period was updated
//     locked        interval stable for LOCK_COUNT intervals
//     overflow      sticky: no toggle seen within 2^CNT_W-1 cycles
//
//   Build option:
//     CLK_RATIO_TOL_EN  when defined, an interval within +/-1 of the
//                       reference counts as a match (absorbs sync jitter).

module clk_ratio_detector #(
    parameter int CNT_W      = 16,
    parameter int LOCK_COUNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_in,
    input  logic             clr,
    output logic             clk_in_sync,
    output logic             edge_det,
    output logic [CNT_W-1:0] half_period,
    output logic             period_valid,
    output logic             locked,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [3:0]       LOCK_N  = 4'(LOCK_COUNT);

    typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;

    state_t           state, state_nxt;
    logic             s1, s2, s3;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] ref_val, ref_nxt;
    logic [CNT_W-1:0] hp_nxt;
    logic [CNT_W-1:0] diff;
    logic [3:0]       match_cnt, match_nxt, match_inc;
    logic             locked_nxt, pv_nxt, ovf_nxt, is_match;

    assign clk_in_sync = s2;

    // Synchronizer, history flop and registered toggle detect.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            s3       <= 1'b0;
            edge_det <= 1'b0;
        end else begin
            s1       <= clk_in;
            s2       <= s1;
            s3       <= s2;
            edge_det <= s2 ^ s3;
        end
    end

    // Interval counter: an edge restarts at 1 so the value seen on the next
    // edge equals the number of clk cycles between the two edges.
    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (edge_det)
            cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
        else if (cnt != CNT_MAX)
            cnt <= cnt + 1'b1;
    end

    // match_cnt == 0 means no reference has been captured yet, so the first
    // measured interval can never match the stale/zero reference.
    always_comb begin
        diff = (cnt >= ref_val) ? (cnt - ref_val) : (ref_val - cnt);
`ifdef CLK_RATIO_TOL_EN
        is_match = (match_cnt != 4'd0) && (diff <= CNT_W'(1));
`else
        is_match = (match_cnt != 4'd0) && (diff == '0);
`endif
        match_inc = match_cnt + 4'd1;
    end

    always_comb begin
        state_nxt  = state;
        ref_nxt    = ref_val;
        match_nxt  = match_cnt;
        locked_nxt = locked;
        pv_nxt     = 1'b0;
        hp_nxt     = half_period;
        ovf_nxt    = overflow;
        if (clr) begin
            // Any coincident edge is dropped; half_period is kept.
            state_nxt  = IDLE;
            ref_nxt    = '0;
            match_nxt  = 4'd0;
            locked_nxt = 1'b0;
            ovf_nxt    = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (edge_det)
                        state_nxt = MEASURE;
                end
                MEASURE, LOCKED: begin
                    if (cnt == CNT_MAX) begin
                        // Timeout wins over a coincident edge.
                        ovf_nxt    = 1'b1;
                        state_nxt  = IDLE;
                        locked_nxt = 1'b0;
                        match_nxt  = 4'd0;
                    end else if (edge_det) begin
                        pv_nxt = 1'b1;
                        hp_nxt = cnt;
                        if (is_match) begin
                            if (state == MEASURE) begin
                                match_nxt = match_inc;
                                if (match_inc >= LOCK_N) begin
                                    state_nxt  = LOCKED;
                                    locked_nxt = 1'b1;
                                end
                            end
                        end else begin
                            ref_nxt   = cnt;
                            match_nxt = 4'd1;
                            if (state == MEASURE && LOCK_N <= 4'd1) begin
                                state_nxt  = LOCKED;
                                locked_nxt = 1'b1;
                            end else begin
                                state_nxt  = MEASURE;
                                locked_nxt = 1'b0;
                            end
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ref_val      <= '0;
            match_cnt    <= 4'd0;
            locked       <= 1'b0;
            period_valid <= 1'b0;
            half_period  <= '0;
            overflow     <= 1'b0;
        end else begin
            state        <= state_nxt;
            ref_val      <= ref_nxt;
            match_cnt    <= match_nxt;
            locked       <= locked_nxt;
            period_valid <= pv_nxt;
            half_period  <= hp_nxt;
            overflow     <= ovf_nxt;
        end
    end

endmodule
